// File: rtl/axis_frame_length.sv
// Passive AXI4-Stream frame length monitor: sums the bytes of every accepted beat
// and strobes the frame total for one cycle after the tlast beat.
module axis_frame_length #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned LEN_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [KEEP_WIDTH-1:0] monitor_axis_tkeep,
  input  logic                  monitor_axis_tvalid,
  input  logic                  monitor_axis_tready,
  input  logic                  monitor_axis_tlast,
  output logic [LEN_WIDTH-1:0]  frame_len,
  output logic                  frame_len_valid
);

  logic [LEN_WIDTH-1:0] r_frame_len;
  logic                 r_frame_len_valid;
  // Set on a tlast beat and held through idle cycles so the next frame restarts at zero.
  logic                 r_frame_done;

  logic                 w_beat;
  logic [LEN_WIDTH-1:0] w_beat_bytes;
  logic [LEN_WIDTH-1:0] w_base;
  logic [LEN_WIDTH-1:0] w_frame_len_next;
  logic                 w_frame_len_valid_next;
  logic                 w_frame_done_next;

  assign w_beat = monitor_axis_tvalid && monitor_axis_tready;

  if (KEEP_ENABLE != 0) begin : g_keep
    // Byte count of the beat is the popcount of tkeep, zero-extended.
    always_comb begin
      w_beat_bytes = '0;
      for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
        w_beat_bytes = w_beat_bytes + LEN_WIDTH'(monitor_axis_tkeep[i]);
      end
    end
  end else begin : g_no_keep
    // tkeep is ignored; every beat carries a full word.
    logic w_unused_tkeep;
    assign w_unused_tkeep = ^monitor_axis_tkeep;
    assign w_beat_bytes   = LEN_WIDTH'(KEEP_WIDTH);
  end

  // Next-state: accumulate on accepted beats, restart after a finished frame.
  always_comb begin
    w_base                 = r_frame_done ? '0 : r_frame_len;
    w_frame_len_next       = r_frame_len;
    w_frame_len_valid_next = 1'b0;
    w_frame_done_next      = r_frame_done;
    if (w_beat) begin
      w_frame_len_next       = w_base + w_beat_bytes;
      w_frame_len_valid_next = monitor_axis_tlast;
      w_frame_done_next      = monitor_axis_tlast;
    end
  end

  // State registers with synchronous active-low reset taking priority over beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_frame_len       <= '0;
      r_frame_len_valid <= 1'b0;
      r_frame_done      <= 1'b0;
    end else begin
      r_frame_len       <= w_frame_len_next;
      r_frame_len_valid <= w_frame_len_valid_next;
      r_frame_done      <= w_frame_done_next;
    end
  end

  assign frame_len       = r_frame_len;
  assign frame_len_valid = r_frame_len_valid;

endmodule

// File: tb/tb_axis_frame_length.sv
// Directed bench for axis_frame_length: three instances share one control stream
// (8-bit word, 64-bit with tkeep popcount, 64-bit with tkeep ignored).
module tb_axis_frame_length;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [0:0]  tkeep8;
  logic [7:0]  tkeep64;

  logic [15:0] len8;
  logic [15:0] len64k;
  logic [15:0] len64n;
  logic        vld8;
  logic        vld64k;
  logic        vld64n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  axis_frame_length #(
    .DATA_WIDTH (8)
  ) u_dut8 (
    .clk                 (clk),
    .rst                 (rst),
    .monitor_axis_tkeep  (tkeep8),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .frame_len           (len8),
    .frame_len_valid     (vld8)
  );

  axis_frame_length #(
    .DATA_WIDTH (64)
  ) u_dut64k (
    .clk                 (clk),
    .rst                 (rst),
    .monitor_axis_tkeep  (tkeep64),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .frame_len           (len64k),
    .frame_len_valid     (vld64k)
  );

  axis_frame_length #(
    .DATA_WIDTH  (64),
    .KEEP_ENABLE (0)
  ) u_dut64n (
    .clk                 (clk),
    .rst                 (rst),
    .monitor_axis_tkeep  (tkeep64),
    .monitor_axis_tvalid (tvalid),
    .monitor_axis_tready (tready),
    .monitor_axis_tlast  (tlast),
    .frame_len           (len64n),
    .frame_len_valid     (vld64n)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int e8, input int e64k, input int e64n,
                           input logic ev);
    chk({tag, "/len8"},   len8,   16'(e8));
    chk({tag, "/len64k"}, len64k, 16'(e64k));
    chk({tag, "/len64n"}, len64n, 16'(e64n));
    chk({tag, "/vld8"},   {15'd0, vld8},   {15'd0, ev});
    chk({tag, "/vld64k"}, {15'd0, vld64k}, {15'd0, ev});
    chk({tag, "/vld64n"}, {15'd0, vld64n}, {15'd0, ev});
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic r, input logic v, input logic rd, input logic l,
                     input logic [7:0] k);
    rst     = r;
    tvalid  = v;
    tready  = rd;
    tlast   = l;
    tkeep8  = 1'b1;
    tkeep64 = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; tkeep8 = 1'b1; tkeep64 = '0;

    // Reset held for two cycles.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    check_all("reset", 0, 0, 0, 1'b0);

    // Stall: tvalid without tready, even with tlast, counts nothing.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
    end
    check_all("stall", 0, 0, 0, 1'b0);

    // Two-beat frame.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    check_all("f2_beat0", 1, 8, 8, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h0F);
    check_all("f2_last", 2, 12, 16, 1'b1);

    // Back-to-back single-beat frame must not carry the previous total.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h01);
    check_all("b2b", 1, 1, 8, 1'b1);

    // Idle (tready without tvalid): strobe drops, length holds.
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
    check_all("idle", 1, 1, 8, 1'b0);

    // Keep counting, with an idle gap after the previous frame and mid-frame.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    check_all("keep_b0", 1, 8, 8, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    check_all("keep_b1", 2, 16, 16, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF);
    check_all("keep_gap", 2, 16, 16, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h0F);
    check_all("keep_last", 3, 20, 24, 1'b1);

    // Zero-byte tkeep beat as its own frame.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00);
    check_all("keep_zero", 1, 0, 8, 1'b1);

    // Mid-frame reset, asserted together with a tlast beat: reset wins.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF);
    check_all("mid_pre", 3, 24, 24, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'hFF);
    check_all("mid_rst", 0, 0, 0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h01);
    check_all("mid_after", 1, 1, 8, 1'b1);

    // 65537 one-byte beats: the 16-bit length wraps.
    for (int i = 0; i < 65537; i++) begin
      cyc(1'b1, 1'b1, 1'b1, (i == 65536), 8'h01);
      if (i == 65534) check_all("wrap_65535", 65535, 65535, 65528, 1'b0);
      if (i == 65535) check_all("wrap_65536", 0, 0, 0, 1'b0);
    end
    check_all("wrap_last", 1, 1, 8, 1'b1);

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    check_all("wrap_idle", 1, 1, 8, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
